// File: rtl/rr_arbiter_fsm_if.sv
// rr_arbiter_fsm_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_fsm_if;
  logic [3:0] r;
  logic [3:0] g;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;
  modport master (output r, input g, busy, owner, timeout);
  modport slave  (input r, output g, busy, owner, timeout);
endinterface

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: four-way round-robin Moore arbiter with bounded hold under contention
module rr_arbiter_fsm #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          resetn,
  rr_arbiter_fsm_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, GNT0 = 3'd1, GNT1 = 3'd2, GNT2 = 3'd3, GNT3 = 3'd4} state_t;
  localparam logic [7:0] MH  = 8'(MAX_HOLD);
  localparam logic [7:0] SAT = (MH == 8'd0) ? 8'hff : MH;
  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic [2:0] sraw;
  logic       in_gnt;
  logic [1:0] cur;
  logic [3:0] mask;
  logic       hit;
  logic [1:0] nxt;
  logic       preempt;
  logic       leave;
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction
  assign sraw    = state_q;
  assign in_gnt  = (sraw >= 3'd1) && (sraw <= 3'd4);
  assign cur     = 2'(sraw - 3'd1);
  assign mask    = in_gnt ? (bus.r & ~(4'b0001 << cur)) : bus.r;
  assign {hit, nxt} = pick(mask, last_q);
  assign preempt = in_gnt && bus.r[cur] && (MH != 8'd0) && (cnt_q == MH) && (|mask);
  assign leave   = !in_gnt || !bus.r[cur] || preempt;
  assign bus.g       = in_gnt ? (4'b0001 << cur) : 4'b0000;
  assign bus.busy    = in_gnt;
  assign bus.owner   = last_q;
  assign bus.timeout = to_q;
  // state, priority pointer, hold counter and preemption flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  // pick the next owner on release or preemption, otherwise keep counting the hold
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (sraw > 3'd4) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (leave) begin
      state_d = hit ? state_t'(3'(nxt) + 3'd1) : IDLE;
      last_d  = hit ? nxt : last_q;
      cnt_d   = hit ? 8'd1 : 8'd0;
      to_d    = hit && preempt;
    end else begin
      cnt_d   = (cnt_q == SAT) ? cnt_q : cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// tb_rr_arbiter_fsm: scoreboard bench over three MAX_HOLD variants sharing one request vector
module tb_rr_arbiter_fsm;
  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      nm;
  } ent_t;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] rv = 4'b0000;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         sel = 0;
  ent_t       q[$];
  rr_arbiter_fsm_if bus8();
  rr_arbiter_fsm_if bus3();
  rr_arbiter_fsm_if bus0();
  assign bus8.r = rv;
  assign bus3.r = rv;
  assign bus0.r = rv;
  rr_arbiter_fsm u8 (.clk(clk), .resetn(resetn), .bus(bus8));
  rr_arbiter_fsm #(.MAX_HOLD(3)) u3 (.clk(clk), .resetn(resetn), .bus(bus3));
  rr_arbiter_fsm #(.MAX_HOLD(0)) u0 (.clk(clk), .resetn(resetn), .bus(bus0));
  logic [7:0] o8, o3, o0;
  assign o8 = {bus8.g, bus8.busy, bus8.owner, bus8.timeout};
  assign o3 = {bus3.g, bus3.busy, bus3.owner, bus3.timeout};
  assign o0 = {bus0.g, bus0.busy, bus0.owner, bus0.timeout};
  always #5 clk = ~clk;
  // monitor: one expected entry per falling edge, compared against the selected instance
  initial begin
    ent_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = (e.sel == 8) ? o8 : (e.sel == 3) ? o3 : o0;
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got g=%b busy=%b owner=%0d timeout=%b, want g=%b busy=%b owner=%0d timeout=%b",
                   e.nm, act[7:4], act[3], act[2:1], act[0], e.exp[7:4], e.exp[3], e.exp[2:1], e.exp[0]);
        end
      end
    end
  end
  task automatic cyc(input logic [3:0] r_in, input logic [3:0] eg, input logic [1:0] eo, input logic et, input string nm);
    ent_t e;
    rv    = r_in;
    e.sel = sel;
    e.exp = {eg, |eg, eo, et};
    e.nm  = nm;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rv     = 4'b0000;
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    #1;
    sel = 8;
    cyc(4'b0000, 4'b0000, 2'd3, 1'b0, "reset_state");
    resetn = 1'b1;
    cyc(4'b0100, 4'b0100, 2'd2, 1'b0, "single_grant");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "single_release");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "idle_keeps_owner");
    rst_pulse();
    cyc(4'b1111, 4'b0001, 2'd0, 1'b0, "rot_g0a");
    cyc(4'b1111, 4'b0001, 2'd0, 1'b0, "rot_g0b");
    cyc(4'b1110, 4'b0010, 2'd1, 1'b0, "rot_g1a");
    cyc(4'b1111, 4'b0010, 2'd1, 1'b0, "rot_g1b");
    cyc(4'b1101, 4'b0100, 2'd2, 1'b0, "rot_g2a");
    cyc(4'b1111, 4'b0100, 2'd2, 1'b0, "rot_g2b");
    cyc(4'b1011, 4'b1000, 2'd3, 1'b0, "rot_g3a");
    cyc(4'b1111, 4'b1000, 2'd3, 1'b0, "rot_g3b");
    cyc(4'b0111, 4'b0001, 2'd0, 1'b0, "rot_wrap_g0");
    cyc(4'b1111, 4'b0001, 2'd0, 1'b0, "rot_wrap_hold");
    cyc(4'b0000, 4'b0000, 2'd0, 1'b0, "rot_idle");
    sel = 3;
    rst_pulse();
    cyc(4'b0001, 4'b0001, 2'd0, 1'b0, "pre_hold1");
    cyc(4'b0101, 4'b0001, 2'd0, 1'b0, "pre_hold2");
    cyc(4'b0101, 4'b0001, 2'd0, 1'b0, "pre_hold3");
    cyc(4'b0101, 4'b0100, 2'd2, 1'b1, "pre_switch_to2");
    cyc(4'b0101, 4'b0100, 2'd2, 1'b0, "pre_timeout_pulse");
    cyc(4'b0101, 4'b0100, 2'd2, 1'b0, "pre_hold2_3");
    cyc(4'b0101, 4'b0001, 2'd0, 1'b1, "pre_switch_to0");
    cyc(4'b0000, 4'b0000, 2'd0, 1'b0, "pre_idle");
    rst_pulse();
    for (int i = 0; i < 20; i++) cyc(4'b0010, 4'b0010, 2'd1, 1'b0, $sformatf("solo_hold%0d", i));
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "solo_release");
    sel = 8;
    rst_pulse();
    cyc(4'b1000, 4'b1000, 2'd3, 1'b0, "mid_grant3");
    cyc(4'b1000, 4'b1000, 2'd3, 1'b0, "mid_hold3");
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus8.g !== 4'b0000 || bus8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_grant: got g=%b busy=%b, want g=0000 busy=0", bus8.g, bus8.busy);
    end
    rv = 4'b1001;
    #1;
    resetn = 1'b1;
    cyc(4'b1001, 4'b0001, 2'd0, 1'b0, "post_reset_g0");
    cyc(4'b1001, 4'b0001, 2'd0, 1'b0, "post_reset_hold");
    cyc(4'b1000, 4'b1000, 2'd3, 1'b0, "post_reset_g3");
    cyc(4'b0000, 4'b0000, 2'd3, 1'b0, "post_reset_idle");
    sel = 0;
    rst_pulse();
    for (int i = 0; i < 50; i++) cyc(4'b0011, 4'b0001, 2'd0, 1'b0, $sformatf("nopre_hold%0d", i));
    cyc(4'b0010, 4'b0010, 2'd1, 1'b0, "nopre_handoff1");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "nopre_idle");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_fsm.md
# rr_arbiter_fsm

Four-requester round-robin arbiter built as a Moore state machine with a bounded hold time. Requesters raise `r[i]` and keep it high while they use the shared resource. The block grants exactly one requester at a time, rotates priority after each grant, and preempts an owner that holds past `MAX_HOLD` cycles while others wait. It sits between the requester FSMs and a shared datapath resource, such as a bus, register port or sequence detector.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while another request is pending. The value 0 disables preemption. Legal range is 0..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to `clk`.
- `r`  in  4  request vector; `r[i]` high means requester i wants or holds the resource.
- `g`  out  4  one-hot grant vector, or all zeros. Decoded from state only (Moore).
- `busy`  out  1  high when any grant is active (`|g`).
- `owner`  out  2  index of the granted requester. Holds the last owner when idle.
- `timeout`  out  1  one-cycle pulse marking the first cycle of a grant obtained by preempting the previous owner.

## Operation
- States: `IDLE`, `GNT0`, `GNT1`, `GNT2`, `GNT3`. In state `GNTk`, `g` has only bit k set. In `IDLE`, `g` = 0.
- Priority pointer `last` (2 bits) holds the index of the most recent owner. Search order is last+1, last+2, last+3, last (mod 4).
- **From IDLE:**
  - If `r` = 0, stay in IDLE.
  - Otherwise go to `GNTj`, where j is the first set bit of `r` in search order.
- **In GNTk, owner releases (`r[k]` = 0):**
  - Go directly to the next requester in search order starting at k+1, excluding k.
  - If no other request is set, go to IDLE.
  - No dead cycle is inserted between owners.
- **In GNTk, owner holds (`r[k]` = 1):**
  - If `MAX_HOLD` ≠ 0, `hold_cnt` = `MAX_HOLD`, and any other `r` bit is set: preempt to the next requester in search order (starting at k+1), and assert `timeout` in the following cycle.
  - Otherwise stay in GNTk.
- `hold_cnt` (8 bits) is 1 in the first cycle of every grant, including a grant to the same index after IDLE. It increments each cycle the grant holds and saturates at `MAX_HOLD`. Value in IDLE is 0.
- `last` and `owner` update to j on every entry into `GNTj`.
- Unused state encodings return to IDLE on the next clock.
- Requests that are not granted are ignored. The arbiter holds no pending memory beyond the `r` levels.

## Timing
- **Reset values:**
  - state = IDLE, so `g` = 4'b0000 and `busy` = 0.
  - `owner` = 2'd3 and `last` = 3, so index 0 has first priority after reset.
  - `timeout` = 0 and `hold_cnt` = 0.
- **Request latency:** `r[j]` sampled high at edge n in IDLE gives `g[j]` = 1 from edge n until the next state change (one-cycle latency).
- **Release latency:** `r[k]` sampled low at edge n gives `g[k]` = 0 after edge n. The next owner's grant appears on that same edge.
- **Grant length under contention:** with `MAX_HOLD` = M > 0 and contention present, a holding owner sees exactly M consecutive grant cycles.
- **Same-edge events:** simultaneous release and new requests at the same edge are resolved by the search order. The releasing index is never re-granted on that edge.
- **Reset mid-grant:** `g` drops to 0 asynchronously and `last` resets to 3. Grant history is discarded.
- **Outputs:** `g`, `busy` and `owner` are pure functions of registered state, with no combinational path from `r`.

## Test plan
- **Reset, then single request:** reset, then `r` = 4'b0100 → `g` = 4'b0100 one cycle later, `owner` = 2, `busy` = 1. Then `r` = 0 → `g` = 0 next cycle.
- **Round-robin rotation:** `r` = 4'b1111, with each owner dropping its request after 2 cycles and re-raising it 1 cycle later → grants cycle 0,1,2,3,0, back-to-back with no IDLE cycles.
- **Preemption:**
  - Setup: `MAX_HOLD` = 3; `r` = 4'b0001 held, then `r[2]` raised at cycle 1.
  - Required: `g[0]` high for exactly 3 cycles, then `g` = 4'b0100 with `timeout` = 1 for one cycle, `owner` = 2.
- **No preemption without contention:** `MAX_HOLD` = 3, only `r[1]` held for 20 cycles → `g` = 4'b0010 for all 20 cycles, `timeout` never asserts.
- **Mid-grant reset:** `r` = 4'b1000 granted, `resetn` pulsed low between clock edges → `g` = 0 immediately. After release with `r` = 4'b1001, the first grant is index 0.
- **Preemption disabled:** `MAX_HOLD` = 0, `r` = 4'b0011 with `r[0]` held 50 cycles → `g` = 4'b0001 for all 50 cycles. Index 1 is granted on the cycle after `r[0]` falls.
